// File: rtl/player_sprite_tracker_pkg.sv
// Shared definitions for the player sprite tracker.
//   fsm_state_t   : per-frame update sequencer states
//   SCREEN_W/H    : visible area in pixels
//   SPRITE_W/H    : sprite footprint in pixels
//   clamp_coord   : saturating clamp of a 10-bit coordinate to an upper limit
package player_sprite_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    STEP  = 2'd2
  } fsm_state_t;

  localparam int COORD_W  = 10;
  localparam int OFFS_W   = 5;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  // Saturate rather than wrap: anything past the limit pins to the limit.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sprite_axis_slew.sv
// Single-axis clamp and rate-limited slew for the sprite position.
//   clk, reset  : clock, synchronous active-high reset
//   latch       : capture clamp(target, limit) as the destination for this frame
//   step        : move cur toward the destination by at most MAX_STEP
//   target      : requested coordinate from software
//   limit       : largest legal sprite edge on this axis
//   cur         : sprite edge currently in use
//   at_target   : 1 when cur equals the latched destination (updated on step)
module sprite_axis_slew
  import player_sprite_tracker_pkg::*;
#(
  parameter int                 MAX_STEP = 4,
  parameter logic [COORD_W-1:0] INIT     = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               latch,
  input  logic               step,
  input  logic [COORD_W-1:0] target,
  input  logic [COORD_W-1:0] limit,
  output logic [COORD_W-1:0] cur,
  output logic               at_target
);

  localparam logic [COORD_W:0] STEP_MAG = (COORD_W+1)'(MAX_STEP);

  logic        [COORD_W-1:0] t_p0;
  logic signed [COORD_W:0]   diff;
  logic        [COORD_W:0]   mag;
  logic        [COORD_W:0]   cur_up;
  logic        [COORD_W:0]   cur_dn;
  logic        [COORD_W-1:0] cur_nxt;

  // Destination register: data only, always written by a latch before any step uses it.
  always_ff @(posedge clk) begin
    if (latch) begin
      t_p0 <= clamp_coord(target, limit);
    end
  end

  // Signed 11-bit difference so distances near 0 or near the limit never underflow.
  always_comb begin
    diff    = $signed({1'b0, t_p0}) - $signed({1'b0, cur});
    mag     = diff[COORD_W] ? $unsigned(-diff) : $unsigned(diff);
    cur_up  = {1'b0, cur} + STEP_MAG;
    cur_dn  = {1'b0, cur} - STEP_MAG;
    cur_nxt = cur;
    if (mag <= STEP_MAG) begin
      cur_nxt = t_p0;
    end else if (diff[COORD_W]) begin
      cur_nxt = cur_dn[COORD_W-1:0];
    end else begin
      cur_nxt = cur_up[COORD_W-1:0];
    end
  end

  // Stage p1: committed position, only ever moves during the step cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= INIT;
      at_target <= 1'b1;
    end else if (step) begin
      cur       <= cur_nxt;
      at_target <= (cur_nxt == t_p0);
    end
  end

endmodule

// File: rtl/player_sprite_tracker.sv
// Player sprite tracker: samples software-written X/Y once per frame on the
// VSYNC falling edge, slews the sprite toward the clamped request, and
// produces a registered per-pixel hit with sprite ROM offsets.
//   clk, reset           : clock, synchronous active-high reset
//   target_x, target_y   : requested position from the PIO ports
//   vga_vs               : VSYNC, active low
//   draw_x, draw_y       : current pixel being drawn
//   cur_x, cur_y         : sprite top-left in use this frame
//   moving               : 1 while cur differs from the clamped target
//   sprite_hit           : pixel (from previous cycle) lies inside the sprite
//   sprite_col/row       : offset of that pixel within the sprite, 0 on miss
module player_sprite_tracker
  import player_sprite_tracker_pkg::*;
#(
  parameter int                 MAX_STEP = 4,
  parameter logic [COORD_W-1:0] INIT_X   = 10'd304,
  parameter logic [COORD_W-1:0] INIT_Y   = 10'd400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] target_x,
  input  logic [COORD_W-1:0] target_y,
  input  logic               vga_vs,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               moving,
  output logic               sprite_hit,
  output logic [OFFS_W-1:0]  sprite_col,
  output logic [OFFS_W-1:0]  sprite_row
);

  localparam logic [COORD_W-1:0] LIMIT_X = COORD_W'(SCREEN_W - SPRITE_W);
  localparam logic [COORD_W-1:0] LIMIT_Y = COORD_W'(SCREEN_H - SPRITE_H);
  localparam logic [COORD_W:0]   SPR_W   = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0]   SPR_H   = (COORD_W+1)'(SPRITE_H);

  fsm_state_t state, state_nxt;
  logic       vs_prev;
  logic       frame_tick;
  logic       do_latch;
  logic       do_step;
  logic       at_x;
  logic       at_y;

  // Frame tick: one cycle at the VSYNC falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev <= 1'b1;
    end else begin
      vs_prev <= vga_vs;
    end
  end

  assign frame_tick = vs_prev & ~vga_vs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ticks seen in LATCH or STEP are dropped; the next frame catches up.
  always_comb begin
    state_nxt = state;
    do_latch  = 1'b0;
    do_step   = 1'b0;
    case (state)
      IDLE:    if (frame_tick) state_nxt = LATCH;
      LATCH: begin
        do_latch  = 1'b1;
        state_nxt = STEP;
      end
      STEP: begin
        do_step   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sprite_axis_slew #(
    .MAX_STEP (MAX_STEP),
    .INIT     (INIT_X)
  ) u_axis_x (
    .clk       (clk),
    .reset     (reset),
    .latch     (do_latch),
    .step      (do_step),
    .target    (target_x),
    .limit     (LIMIT_X),
    .cur       (cur_x),
    .at_target (at_x)
  );

  sprite_axis_slew #(
    .MAX_STEP (MAX_STEP),
    .INIT     (INIT_Y)
  ) u_axis_y (
    .clk       (clk),
    .reset     (reset),
    .latch     (do_latch),
    .step      (do_step),
    .target    (target_y),
    .limit     (LIMIT_Y),
    .cur       (cur_y),
    .at_target (at_y)
  );

  assign moving = ~(at_x & at_y);

  // Stage p0: bound compares on 11-bit sums so cur + 32 never wraps.
  logic              in_p0;
  logic [OFFS_W-1:0] col_p0;
  logic [OFFS_W-1:0] row_p0;

  always_comb begin
    in_p0  = (draw_x >= cur_x) && ({1'b0, draw_x} < ({1'b0, cur_x} + SPR_W)) &&
             (draw_y >= cur_y) && ({1'b0, draw_y} < ({1'b0, cur_y} + SPR_H));
    // Low bits of a difference depend only on the low bits of the operands.
    col_p0 = draw_x[OFFS_W-1:0] - cur_x[OFFS_W-1:0];
    row_p0 = draw_y[OFFS_W-1:0] - cur_y[OFFS_W-1:0];
  end

  // Stage p1: registered hit and offsets, offsets forced to 0 on a miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      sprite_hit <= 1'b0;
      sprite_col <= '0;
      sprite_row <= '0;
    end else begin
      sprite_hit <= in_p0;
      sprite_col <= in_p0 ? col_p0 : '0;
      sprite_row <= in_p0 ? row_p0 : '0;
    end
  end

endmodule

// File: tb/tb_player_sprite_tracker.sv
module tb_player_sprite_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] target_x, target_y, draw_x, draw_y;
  logic       vga_vs;
  logic [9:0] cur_x, cur_y;
  logic       moving, sprite_hit;
  logic [4:0] sprite_col, sprite_row;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  player_sprite_tracker dut (
    .clk        (clk),
    .reset      (reset),
    .target_x   (target_x),
    .target_y   (target_y),
    .vga_vs     (vga_vs),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .moving     (moving),
    .sprite_hit (sprite_hit),
    .sprite_col (sprite_col),
    .sprite_row (sprite_row)
  );

  typedef struct {
    int tx;
    int ty;
    int ex;
    int ey;
    int emov;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full frame: VSYNC low for 3 cycles (tick, LATCH, STEP), then high.
  task automatic frame();
    vga_vs = 1'b0;
    cyc(3);
    vga_vs = 1'b1;
    cyc(2);
  endtask

  task automatic pos_check(input string name, input int ex, input int ey, input int emov);
    check({name, " cur_x"}, cur_x, ex);
    check({name, " cur_y"}, cur_y, ey);
    check({name, " moving"}, moving, emov);
  endtask

  initial begin
    vecs[0] = '{310, 400, 308, 400, 1};
    vecs[1] = '{310, 400, 310, 400, 0};
    vecs[2] = '{310, 402, 310, 402, 0};
    vecs[3] = '{305, 450, 306, 406, 1};
    vecs[4] = '{0,   0,   302, 402, 1};
    vecs[5] = '{301, 401, 301, 401, 0};
    vecs[6] = '{301, 397, 301, 397, 0};

    reset    = 1'b1;
    vga_vs   = 1'b1;
    target_x = 10'd0;
    target_y = 10'd0;
    draw_x   = 10'd0;
    draw_y   = 10'd0;
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // Reset state, no ticks
    pos_check("reset", 304, 400, 0);
    check("reset hit", sprite_hit, 0);
    check("reset col", sprite_col, 0);
    check("reset row", sprite_row, 0);
    target_x = 10'd500;
    target_y = 10'd100;
    cyc(4);
    pos_check("no tick", 304, 400, 0);
    draw_x = 10'd320;
    draw_y = 10'd410;
    cyc(1);
    check("init hit", sprite_hit, 1);
    check("init col", sprite_col, 16);
    check("init row", sprite_row, 10);
    draw_x = 10'd0;
    draw_y = 10'd0;
    cyc(1);
    check("origin hit", sprite_hit, 0);

    // Table-driven slew vectors, one frame each
    for (int i = 0; i < 7; i++) begin
      target_x = 10'(vecs[i].tx);
      target_y = 10'(vecs[i].ty);
      frame();
      pos_check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].emov);
    end

    // Move to (100,200) for the hit sweep
    target_x = 10'd100;
    target_y = 10'd200;
    for (int i = 0; i < 60; i++) frame();
    pos_check("park", 100, 200, 0);

    // Sweep draw_x 99..132 at draw_y 200; hit must lag draw_x by one cycle
    draw_y = 10'd200;
    draw_x = 10'd99;
    cyc(1);
    for (int x = 99; x <= 132; x++) begin
      draw_x = 10'(x);
      #1;
      check($sformatf("lag x%0d", x), sprite_hit, ((x - 1) >= 100 && (x - 1) <= 131) ? 1 : 0);
      cyc(1);
      check($sformatf("hit x%0d", x), sprite_hit, (x >= 100 && x <= 131) ? 1 : 0);
      check($sformatf("col x%0d", x), sprite_col, (x >= 100 && x <= 131) ? (x - 100) : 0);
    end
    draw_x = 10'd105;
    draw_y = 10'd231;
    cyc(1);
    check("row31 hit", sprite_hit, 1);
    check("row31 row", sprite_row, 31);
    check("row31 col", sprite_col, 5);
    draw_y = 10'd232;
    cyc(1);
    check("row32 hit", sprite_hit, 0);
    check("row32 row", sprite_row, 0);
    draw_y = 10'd199;
    cyc(1);
    check("row-1 hit", sprite_hit, 0);

    // Only the target present at LATCH is used
    target_x = 10'd90;
    target_y = 10'd200;
    cyc(5);
    target_x = 10'd120;
    target_y = 10'd210;
    cyc(3);
    target_x = 10'd103;
    target_y = 10'd202;
    vga_vs = 1'b0;
    cyc(1);
    pos_check("pre latch", 100, 200, 0);
    cyc(1);
    target_x = 10'd0;
    target_y = 10'd0;
    cyc(1);
    vga_vs = 1'b1;
    cyc(2);
    pos_check("latch snap", 103, 202, 0);

    // A second tick landing in STEP is dropped: only one step occurs
    vga_vs = 1'b0;
    cyc(1);
    vga_vs = 1'b1;
    cyc(1);
    vga_vs = 1'b0;
    cyc(4);
    pos_check("tick in STEP", 99, 198, 1);
    vga_vs = 1'b1;
    cyc(2);

    // Reset during STEP wins over the update
    vga_vs = 1'b0;
    cyc(2);
    reset  = 1'b1;
    vga_vs = 1'b1;
    cyc(1);
    reset = 1'b0;
    pos_check("reset in STEP", 304, 400, 0);
    cyc(3);
    pos_check("after reset idle", 304, 400, 0);
    frame();
    pos_check("slew after reset", 300, 396, 1);

    // Saturation at the right/bottom limit
    target_x = 10'd700;
    target_y = 10'd1000;
    for (int i = 0; i < 80; i++) begin
      frame();
      check("x bound hi", (cur_x <= 608) ? 1 : 0, 1);
    end
    pos_check("sat hi", 608, 448, 0);
    frame();
    frame();
    pos_check("sat hi hold", 608, 448, 0);

    // Approach 0 without wrapping
    target_x = 10'd0;
    target_y = 10'd0;
    for (int i = 0; i < 160; i++) begin
      frame();
      check("x bound lo", (cur_x <= 608) ? 1 : 0, 1);
    end
    pos_check("sat lo", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
